seven_segment_dual_decoder: RTL and testbench
=============================================

Name: seven_segment_dual_decoder

Overview:
Registered BCD-to-seven-segment decoder with two simultaneous output polarities. The active-high segment bus drives common-cathode displays. The active-low bus is the bitwise inverse and drives common-anode displays. It sits between digit/counter logic and the display pins, with one register stage so segment outputs are glitch-free.

Parameters:
SIX_TAIL, 1, 1: digit 6 lights segment a; 0: digit 6 omits segment a.
NINE_TAIL, 1, 1: digit 9 lights segment d; 0: digit 9 omits segment d.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
en  input  1  load enable; when 1, decoded value is captured on the clk edge
digit  input  4  binary digit to display; bit 3 is MSB (A), bit 0 is LSB (D)
blank  input  1  forces all segments off
lamp_test  input  1  forces all segments on
seg_hi  output  7  active-high segments, [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g
seg_lo  output  7  active-low segments, same bit order; always equal to ~seg_hi
invalid  output  1  registered flag: last captured digit was out of display range

Behaviour:
- Reset (rst=1, asynchronous, any time): seg_hi=7'b0000000, seg_lo=7'b1111111, invalid=0. Held while rst=1; first capture is on the first clk edge after release with en=1.
- Latency: 1 clk. Outputs reflect inputs sampled at the rising edge where en=1. With en=0, all outputs hold.
- Capture priority: lamp_test > blank > digit.
  - lamp_test=1: seg_hi=1111111, invalid=0.
  - blank=1: seg_hi=0000000, invalid=0.
- Digit decode, seg_hi as abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - SIX_TAIL=0 gives 6=0011111; NINE_TAIL=0 gives 9=1110011.
- Digits 10..15 without the optional feature: seg_hi=0000000 (blank), invalid=1.
- seg_lo is derived from the seg_hi register (inverse), never decoded separately, so the two buses can never disagree, including during reset.
- No combinational path from inputs to outputs.

Optional Feature:
HEX_DIGITS_EN
- Defined: digits 10..15 display hex glyphs and invalid stays 0.
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Not defined: 10..15 blank with invalid=1, as in Behaviour.

Test Plan:
- rst=1 mid-run, no clk edge -> seg_hi=0000000, seg_lo=1111111, invalid=0 immediately.
- en=1, sweep digit 0..9 -> one clk later:
  - 0 gives seg_hi=1111110 / seg_lo=0000001.
  - 1 gives seg_hi=0110000 / seg_lo=1001111.
  - 9 gives seg_hi=1111011 / seg_lo=0000100.
  - All 10 values checked.
- en=1, digit=4'b1010 -> without HEX_DIGITS_EN: seg_hi=0000000, invalid=1; with it: seg_hi=1110111, invalid=0.
- digit=8 captured, then en=0 with digit=1 for 3 clks -> seg_hi stays 1111111.
- en=1, digit=2, blank=1, lamp_test=1 -> seg_hi=1111111. Drop lamp_test -> seg_hi=0000000. Drop blank -> seg_hi=1101101.
- Every cycle of every test -> assert seg_lo == ~seg_hi.

Source files
------------

// File: rtl/seven_segment_dual_decoder.sv
// Registered BCD/hex digit to seven-segment decoder with active-high and active-low buses.
// Latency: 1 clk from a capture (en=1) edge to seg_hi/seg_lo/invalid; outputs hold while en=0.
// Backpressure: none; en is a plain load enable. Optional hex glyphs for 10..15 under HEX_DIGITS_EN.
module seven_segment_dual_decoder #(
  parameter int unsigned SIX_TAIL  = 1,  // nonzero: digit 6 lights segment a
  parameter int unsigned NINE_TAIL = 1   // nonzero: digit 9 lights segment d
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] seg_hi,
  output logic [6:0] seg_lo,
  output logic       invalid
);

  // Segment order in every constant below: [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_ALL = 7'b1111111;

  localparam logic [6:0] GLYPH_0      = 7'b1111110;
  localparam logic [6:0] GLYPH_1      = 7'b0110000;
  localparam logic [6:0] GLYPH_2      = 7'b1101101;
  localparam logic [6:0] GLYPH_3      = 7'b1111001;
  localparam logic [6:0] GLYPH_4      = 7'b0110011;
  localparam logic [6:0] GLYPH_5      = 7'b1011011;
  localparam logic [6:0] GLYPH_6_TAIL = 7'b1011111;
  localparam logic [6:0] GLYPH_6_BARE = 7'b0011111;
  localparam logic [6:0] GLYPH_7      = 7'b1110000;
  localparam logic [6:0] GLYPH_8      = 7'b1111111;
  localparam logic [6:0] GLYPH_9_TAIL = 7'b1111011;
  localparam logic [6:0] GLYPH_9_BARE = 7'b1110011;

`ifdef HEX_DIGITS_EN
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;
`endif

  // Tail style is fixed at elaboration, so resolve the 6/9 glyphs once.
  localparam logic [6:0] GLYPH_6 = (SIX_TAIL  != 0) ? GLYPH_6_TAIL : GLYPH_6_BARE;
  localparam logic [6:0] GLYPH_9 = (NINE_TAIL != 0) ? GLYPH_9_TAIL : GLYPH_9_BARE;

  // Everything the display register holds, kept together so it loads as one unit.
  typedef struct packed {
    logic [6:0] seg;
    logic       invalid;
  } disp_t;

  disp_t disp_nxt;
  disp_t disp_q;

  // Decode the digit into a glyph; out-of-range digits blank and raise invalid.
  disp_t digit_dec;
  always_comb begin
    digit_dec.seg     = SEG_OFF;
    digit_dec.invalid = 1'b0;
    case (digit)
      4'd0:    digit_dec.seg = GLYPH_0;
      4'd1:    digit_dec.seg = GLYPH_1;
      4'd2:    digit_dec.seg = GLYPH_2;
      4'd3:    digit_dec.seg = GLYPH_3;
      4'd4:    digit_dec.seg = GLYPH_4;
      4'd5:    digit_dec.seg = GLYPH_5;
      4'd6:    digit_dec.seg = GLYPH_6;
      4'd7:    digit_dec.seg = GLYPH_7;
      4'd8:    digit_dec.seg = GLYPH_8;
      4'd9:    digit_dec.seg = GLYPH_9;
`ifdef HEX_DIGITS_EN
      4'd10:   digit_dec.seg = GLYPH_A;
      4'd11:   digit_dec.seg = GLYPH_B;
      4'd12:   digit_dec.seg = GLYPH_C;
      4'd13:   digit_dec.seg = GLYPH_D;
      4'd14:   digit_dec.seg = GLYPH_E;
      4'd15:   digit_dec.seg = GLYPH_F;
`endif
      default: begin
        digit_dec.seg     = SEG_OFF;
        digit_dec.invalid = 1'b1;
      end
    endcase
  end

  // Apply overrides: lamp test beats blanking, blanking beats the decoded digit.
  always_comb begin
    disp_nxt = digit_dec;
    if (lamp_test) begin
      disp_nxt.seg     = SEG_ALL;
      disp_nxt.invalid = 1'b0;
    end else if (blank) begin
      disp_nxt.seg     = SEG_OFF;
      disp_nxt.invalid = 1'b0;
    end
  end

  // Single output register: captures on en, otherwise holds; reset blanks the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= '{seg: SEG_OFF, invalid: 1'b0};
    end else if (en) begin
      disp_q <= disp_nxt;
    end
  end

  // The active-low bus is taken from the same register so both polarities always agree.
  assign seg_hi  = disp_q.seg;
  assign seg_lo  = ~disp_q.seg;
  assign invalid = disp_q.invalid;

endmodule

// File: tb/tb_seven_segment_dual_decoder.sv
// Directed bench for seven_segment_dual_decoder (default parameters).
// Inputs are driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Expected glyphs are written out by hand from the decode table.
module tb_seven_segment_dual_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] digit;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg_hi;
  logic [6:0] seg_lo;
  logic       invalid;

  int n_chk;
  int n_pass;
  logic running;

  seven_segment_dual_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .digit     (digit),
    .blank     (blank),
    .lamp_test (lamp_test),
    .seg_hi    (seg_hi),
    .seg_lo    (seg_lo),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Polarity cross-check on every falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (running) chk("seg_lo_inverse", seg_lo, ~seg_hi);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] eh, input logic ei);
    chk({tag, "_hi"}, seg_hi, eh);
    chk({tag, "_lo"}, seg_lo, ~eh);
    chk({tag, "_inv"}, {6'b0, invalid}, {6'b0, ei});
  endtask

  logic [6:0] dec_tab [16];
  logic       inv_tab [16];

  initial begin
    dec_tab[0]  = 7'b1111110;
    dec_tab[1]  = 7'b0110000;
    dec_tab[2]  = 7'b1101101;
    dec_tab[3]  = 7'b1111001;
    dec_tab[4]  = 7'b0110011;
    dec_tab[5]  = 7'b1011011;
    dec_tab[6]  = 7'b1011111;
    dec_tab[7]  = 7'b1110000;
    dec_tab[8]  = 7'b1111111;
    dec_tab[9]  = 7'b1111011;
`ifdef HEX_DIGITS_EN
    dec_tab[10] = 7'b1110111;
    dec_tab[11] = 7'b0011111;
    dec_tab[12] = 7'b1001110;
    dec_tab[13] = 7'b0111101;
    dec_tab[14] = 7'b1001111;
    dec_tab[15] = 7'b1000111;
    for (int i = 0; i < 16; i++) inv_tab[i] = 1'b0;
`else
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0000000;
    for (int i = 0; i < 16; i++) inv_tab[i] = (i >= 10);
`endif
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    running = 1'b0;
    rst = 1'b1;
    en = 1'b1;
    digit = 4'd8;
    blank = 1'b0;
    lamp_test = 1'b0;

    // Reset held across edges with en=1 must keep the display blank.
    #2;
    expect_out("reset_init", 7'b0000000, 1'b0);
    tick();
    tick();
    expect_out("reset_held", 7'b0000000, 1'b0);
    rst = 1'b0;
    running = 1'b1;

    // Sweep every digit value, including the out-of-range codes.
    for (int d = 0; d < 16; d++) begin
      digit = d[3:0];
      en = 1'b1;
      tick();
      expect_out($sformatf("digit_%0d", d), dec_tab[d], inv_tab[d]);
    end

    // Out-of-range flag holds with en=0, then a lamp test clears it.
    digit = 4'd10;
    tick();
    en = 1'b0;
    digit = 4'd3;
    tick();
    expect_out("inv_hold", dec_tab[10], inv_tab[10]);
    en = 1'b1;
    lamp_test = 1'b1;
    tick();
    expect_out("lamp_clears_inv", 7'b1111111, 1'b0);
    lamp_test = 1'b0;

    // Blank also clears an out-of-range flag.
    digit = 4'd12;
    tick();
    blank = 1'b1;
    tick();
    expect_out("blank_clears_inv", 7'b0000000, 1'b0);
    blank = 1'b0;

    // Capture 8, then hold three cycles with en=0 and a different digit.
    digit = 4'd8;
    en = 1'b1;
    tick();
    en = 1'b0;
    digit = 4'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_out($sformatf("hold_%0d", c), 7'b1111111, 1'b0);
    end

    // Priority: lamp_test over blank over digit.
    en = 1'b1;
    digit = 4'd2;
    blank = 1'b1;
    lamp_test = 1'b1;
    tick();
    expect_out("prio_lamp", 7'b1111111, 1'b0);
    lamp_test = 1'b0;
    tick();
    expect_out("prio_blank", 7'b0000000, 1'b0);
    blank = 1'b0;
    tick();
    expect_out("prio_digit", 7'b1101101, 1'b0);

    // Asynchronous reset mid-cycle, checked before any further edge.
    digit = 4'd8;
    tick();
    expect_out("pre_async", 7'b1111111, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 7'b0000000, 1'b0);
    tick();
    expect_out("async_rst_held", 7'b0000000, 1'b0);
    rst = 1'b0;
    digit = 4'd0;
    tick();
    expect_out("post_rst_first", 7'b1111110, 1'b0);

    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
